// File: rtl/board_reader_pkg.sv
// Shared game-of-life board constants, mode and live-count state encodings.
package board_reader_pkg;

  localparam int unsigned ROWS      = 16;
  localparam int unsigned COLS      = 16;
  localparam int unsigned BOARD_W   = ROWS * COLS;
  localparam int unsigned ROW_IDX_W = $clog2(ROWS);
  localparam int unsigned COUNT_W   = $clog2(BOARD_W + 1);
  localparam int unsigned POP_W     = $clog2(COLS + 1);

  // Board viewed as rows; row r is the packed element r (bits [16r+15:16r]).
  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    SNAP    = 2'd0,
    COUNT   = 2'd1,
    PUBLISH = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/board_reader_row_popcount.sv
// Combinational population count of one board row.
module row_popcount
  import board_reader_pkg::*;
(
  input  logic [COLS-1:0]  bits,
  output logic [POP_W-1:0] ones_c
);

  // Sum the set bits of the row.
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < COLS; i++) begin
      ones_c = ones_c + POP_W'(bits[i]);
    end
  end

endmodule

// File: rtl/board_reader.sv
// Shows one board row on the LEDs (manual or auto-scrolled) and keeps a
// periodically refreshed live-cell count of the whole board.
module board_reader
  import board_reader_pkg::*;
#(
  parameter int unsigned SCROLL_TICKS = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 BtnU,
  input  logic                 BtnD,
  input  logic                 BtnC,
  input  logic [BOARD_W-1:0]   board_in,
  output logic [COLS-1:0]      row_leds,
  output logic [ROW_IDX_W-1:0] row_index,
  output logic                 auto_mode,
  output logic [COUNT_W-1:0]   live_count,
  output logic                 count_valid
);

  localparam int unsigned TMR_W = $clog2(SCROLL_TICKS);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(SCROLL_TICKS - 1);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(ROWS - 1);

  board_t                 board_rows;
  board_t                 shadow_q;
  logic                   prev_u, prev_d, prev_c;
  logic                   rise_u, rise_d, rise_c;
  mode_t                  mode_q;
  logic [TMR_W-1:0]       timer_q;
  cnt_state_t             state_q, state_d;
  logic [COUNT_W-1:0]     acc_q;
  logic [ROW_IDX_W-1:0]   k_q;
  logic [POP_W-1:0]       row_ones;

  assign board_rows = board_t'(board_in);
  assign auto_mode  = (mode_q == AUTO);

  assign rise_u = BtnU & ~prev_u;
  assign rise_d = BtnD & ~prev_d;
  assign rise_c = BtnC & ~prev_c;

  // Button history tracks the level every cycle, regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_u <= 1'b0;
      prev_d <= 1'b0;
      prev_c <= 1'b0;
    end else begin
      prev_u <= BtnU;
      prev_d <= BtnD;
      prev_c <= BtnC;
    end
  end

  // Mode toggle, scroll timer and row selection; a toggle beats an auto step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MANUAL;
      timer_q   <= '0;
      row_index <= '0;
    end else if (enable) begin
      if (rise_c) begin
        mode_q  <= (mode_q == MANUAL) ? AUTO : MANUAL;
        timer_q <= '0;
      end else if (mode_q == AUTO) begin
        if (timer_q == TMR_LAST) begin
          timer_q   <= '0;
          row_index <= (row_index == ROW_LAST) ? '0 : row_index + ROW_IDX_W'(1);
        end else begin
          timer_q <= timer_q + TMR_W'(1);
        end
      end else if (rise_u && !rise_d && row_index != '0) begin
        row_index <= row_index - ROW_IDX_W'(1);
      end else if (rise_d && !rise_u && row_index != ROW_LAST) begin
        row_index <= row_index + ROW_IDX_W'(1);
      end
    end
  end

  // LED register follows the selected row while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_leds <= '0;
    end else if (enable) begin
      row_leds <= board_rows[row_index];
    end
  end

  // Live-count state register; freezes while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SNAP;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Live-count next state: snapshot, one row per cycle, publish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SNAP:    state_d = COUNT;
      COUNT:   state_d = (k_q == ROW_LAST) ? PUBLISH : COUNT;
      PUBLISH: state_d = SNAP;
      default: state_d = SNAP;
    endcase
  end

  row_popcount u_row_popcount (
    .bits   (shadow_q[k_q]),
    .ones_c (row_ones)
  );

  // Live-count datapath: shadow copy, accumulator and published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      live_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (enable) begin
        unique case (state_q)
          SNAP: begin
            shadow_q <= board_rows;
            acc_q    <= '0;
            k_q      <= '0;
          end
          COUNT: begin
            acc_q <= acc_q + COUNT_W'(row_ones);
            k_q   <= k_q + ROW_IDX_W'(1);
          end
          PUBLISH: begin
            live_count  <= acc_q;
            count_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_reader.sv
// Bench for board_reader: behavioural reference model plus directed scenarios.
module tb_board_reader;

  localparam int TICKS = 4;
  localparam int NROWS = 16;
  localparam int PERIOD = NROWS + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic               BtnU = 1'b0;
  logic               BtnD = 1'b0;
  logic               BtnC = 1'b0;
  logic [15:0][15:0]  brd = '0;
  logic [255:0]       board_in;
  logic [15:0]        row_leds;
  logic [3:0]         row_index;
  logic               auto_mode;
  logic [8:0]         live_count;
  logic               count_valid;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int          m_row   = 0;
  bit          m_auto  = 1'b0;
  int          m_timer = 0;
  logic [15:0] m_leds  = '0;
  int          m_live  = 0;
  bit          m_valid = 1'b0;
  int          m_phase = 0;
  int          m_snap  = 0;
  bit          pu = 1'b0, pd = 1'b0, pc = 1'b0;

  assign board_in = brd;

  board_reader #(.SCROLL_TICKS(TICKS)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .BtnU        (BtnU),
    .BtnD        (BtnD),
    .BtnC        (BtnC),
    .board_in    (board_in),
    .row_leds    (row_leds),
    .row_index   (row_index),
    .auto_mode   (auto_mode),
    .live_count  (live_count),
    .count_valid (count_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: rows selected by clamped button deltas or by timed wrap-around
  // scrolling; the count publishes the board seen 18 enabled cycles earlier.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_row = 0; m_auto = 0; m_timer = 0; m_leds = '0;
      m_live = 0; m_valid = 0; m_phase = 0; m_snap = 0;
      pu = 0; pd = 0; pc = 0;
    end else begin
      bit eu, ed, ec;
      int step;
      eu = BtnU && !pu;
      ed = BtnD && !pd;
      ec = BtnC && !pc;
      if (enable) begin
        m_leds = brd[m_row];
        if (ec) begin
          m_auto  = !m_auto;
          m_timer = 0;
        end else if (m_auto) begin
          m_timer++;
          if (m_timer == TICKS) begin
            m_timer = 0;
            m_row   = (m_row + 1) % NROWS;
          end
        end else begin
          step  = int'(ed) - int'(eu);
          m_row = m_row + step;
          if (m_row < 0) m_row = 0;
          if (m_row > NROWS - 1) m_row = NROWS - 1;
        end
        if (m_phase == 0) m_snap = $countones(board_in);
        m_valid = (m_phase == PERIOD - 1);
        if (m_valid) m_live = m_snap;
        m_phase = (m_phase + 1) % PERIOD;
      end else begin
        m_valid = 0;
      end
      pu = BtnU; pd = BtnD; pc = BtnC;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("row_index", 32'(row_index), 32'(m_row));
      check("row_leds", 32'(row_leds), 32'(m_leds));
      check("auto_mode", 32'(auto_mode), 32'(m_auto));
      check("live_count", 32'(live_count), 32'(m_live));
      check("count_valid", 32'(count_valid), 32'(m_valid));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_d(input int n);
    repeat (n) begin BtnD = 1; tick(1); BtnD = 0; tick(1); end
  endtask

  task automatic pulse_u(input int n);
    repeat (n) begin BtnU = 1; tick(1); BtnU = 0; tick(1); end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (count_valid !== 1'b1 && n < 60);
    if (count_valid !== 1'b1) check("count_valid_timeout", 32'(count_valid), 32'd1);
  endtask

  initial begin
    int n;
    logic [3:0]  saved_row;
    logic [15:0] saved_leds;

    // Reset
    tick(3);
    check("rst_row_index", 32'(row_index), 32'd0);
    check("rst_row_leds", 32'(row_leds), 32'd0);
    check("rst_auto_mode", 32'(auto_mode), 32'd0);
    check("rst_live_count", 32'(live_count), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    rst = 0;
    chk_en = 1;

    // Manual navigation
    pulse_d(3);
    check("row_after_3_down", 32'(row_index), 32'd3);
    brd[3] = 16'hA5F0;
    tick(1);
    check("row_leds_row3", 32'(row_leds), 32'h0000A5F0);
    pulse_u(5);
    check("row_sat_low", 32'(row_index), 32'd0);

    // Bounds and simultaneous edges
    pulse_d(20);
    check("row_sat_high", 32'(row_index), 32'd15);
    BtnU = 1; BtnD = 1; tick(1); BtnU = 0; BtnD = 0; tick(1);
    check("simul_at_15", 32'(row_index), 32'd15);
    pulse_u(1);
    BtnU = 1; BtnD = 1; tick(1); BtnU = 0; BtnD = 0; tick(1);
    check("simul_at_14", 32'(row_index), 32'd14);
    BtnD = 1; tick(100); BtnD = 0; tick(1);
    check("held_single_step", 32'(row_index), 32'd15);

    // Live count: all ones, period, zeros, checkerboard
    brd = '1;
    wait_valid(n);
    wait_valid(n);
    check("period_cycles", 32'(n), 32'(PERIOD));
    check("count_all_ones", 32'(live_count), 32'd256);
    brd = '0;
    wait_valid(n);
    wait_valid(n);
    check("count_all_zeros", 32'(live_count), 32'd0);
    for (int r = 0; r < 16; r++) brd[r] = r[0] ? 16'h5555 : 16'hAAAA;
    wait_valid(n);
    wait_valid(n);
    check("count_checker", 32'(live_count), 32'd128);

    // Board change during COUNT must not disturb the published value
    wait_valid(n);
    brd = '1;
    tick(1);
    tick(3);
    brd = '0;
    wait_valid(n);
    check("count_snap_ones", 32'(live_count), 32'd256);
    wait_valid(n);
    check("count_snap_zeros", 32'(live_count), 32'd0);

    // Auto scroll from row 15 with wrap
    brd[0] = 16'h1234; brd[1] = 16'h8001;
    BtnC = 1; tick(1);
    check("auto_on", 32'(auto_mode), 32'd1);
    BtnC = 0;
    tick(3);
    check("auto_hold_15", 32'(row_index), 32'd15);
    tick(1);
    check("auto_wrap_0", 32'(row_index), 32'd0);
    BtnU = 1; tick(1); BtnU = 0; tick(3);
    check("auto_ignores_btnu", 32'(row_index), 32'd1);
    tick(1);
    check("auto_leds_row1", 32'(row_leds), 32'h00008001);

    // Enable gating mid-COUNT, in auto mode
    wait_valid(n);
    tick(5);
    enable = 0;
    saved_row  = row_index;
    saved_leds = row_leds;
    n = 5;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n++;
      check("gated_no_valid", 32'(count_valid), 32'd0);
    end
    check("gated_row_hold", 32'(row_index), 32'(saved_row));
    check("gated_leds_hold", 32'(row_leds), 32'(saved_leds));
    enable = 1;
    begin
      int m;
      wait_valid(m);
      n += m;
    end
    check("stalled_period", 32'(n), 32'(PERIOD + 10));

    // Back to manual: row freezes
    BtnC = 1; tick(1); BtnC = 0;
    check("auto_off", 32'(auto_mode), 32'd0);
    saved_row = row_index;
    tick(10);
    check("manual_frozen", 32'(row_index), 32'(saved_row));

    // Async reset mid-scroll
    BtnC = 1; tick(1); BtnC = 0;
    tick(6);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_auto_mode", 32'(auto_mode), 32'd0);
    check("arst_row_index", 32'(row_index), 32'd0);
    check("arst_live_count", 32'(live_count), 32'd0);
    check("arst_row_leds", 32'(row_leds), 32'd0);
    check("arst_count_valid", 32'(count_valid), 32'd0);
    tick(2);
    rst = 0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_reader.md
Name: board_reader

Overview:
- Read-side counterpart of the board set-up writer. Takes the flat 256-bit game board (16 rows × 16 cells; row r occupies bits [16r+15:16r]) and shows one row at a time on 16 LEDs.
- The row is chosen by button (manual) or by a timed scroll (auto).
- Also keeps a periodically refreshed live-cell count of the whole board for the status display.
- Sits between the board register or generation engine and the LED / seven-segment drivers.

Parameters:
ROWS, 16, number of board rows; row index width is clog2(ROWS).
COLS, 16, cells per row; LED output width.
SCROLL_TICKS, 50_000_000, clk cycles per row advance in auto mode; must be ≥ 2.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  when low, all state holds (timer, row index, mode, count FSM).
BtnU  input  1  level, already debounced; rising edge selects the previous row.
BtnD  input  1  level, already debounced; rising edge selects the next row.
BtnC  input  1  level, already debounced; rising edge toggles MANUAL/AUTO mode.
board_in  input  ROWS*COLS  flat board, row-major.
row_leds  output  COLS  registered copy of the selected row.
row_index  output  clog2(ROWS)  currently selected row.
auto_mode  output  1  1 = AUTO, 0 = MANUAL.
live_count  output  clog2(ROWS*COLS+1) (9)  live cells in the last completed snapshot.
count_valid  output  1  one-cycle pulse when live_count updates.

Behaviour:
- Reset (async, rst=1): row_index=0, auto_mode=0, row_leds=0, live_count=0, count_valid=0, scroll timer=0, count FSM=SNAP, button history regs=0.
- Edge detect: each button has a one-cycle history register. Edge = level & ~prev. History updates every cycle, even when enable=0, so a button held across an enable rise does not fire.
- All actions below require enable=1.
- BtnC edge: toggles auto_mode and clears the scroll timer.
- MANUAL mode, BtnU edge: row_index−1, saturating at 0.
- MANUAL mode, BtnD edge: row_index+1, saturating at ROWS−1.
- MANUAL mode, BtnU and BtnD edges in the same cycle: no change.
- AUTO mode: the timer counts 0..SCROLL_TICKS−1. At terminal count, row_index increments and wraps ROWS−1→0, and the timer returns to 0. BtnU/BtnD edges are ignored.
- BtnC edge in the same cycle as an auto terminal count: the toggle wins and row_index does not advance.
- row_leds: takes board_in[row_index*COLS +: COLS] every enabled cycle.
  - 1-cycle latency from a row_index change or a board_in change.
  - When enable=0, row_leds holds.
- Live count FSM:
  - SNAP: copy board_in into a shadow register; clear accumulator and row counter; → COUNT.
  - COUNT: each cycle, add popcount(shadow row k) to the accumulator, k=0..ROWS−1; after k=ROWS−1 → PUBLISH.
  - PUBLISH: live_count ← accumulator, count_valid=1 for this cycle only; → SNAP.
  - Period is ROWS+2 = 18 cycles.
- Count width: accumulator is 9 bits; the maximum of 256 must be represented without wrap.
- Count consistency: the count reflects the board as sampled at SNAP. board_in changes during COUNT do not affect the result.
- enable low mid-count: FSM, shadow register and accumulator freeze; the count resumes on the same row when enable returns. count_valid is never asserted while enable=0.
- rst mid-operation: immediate return to reset values; any partial count is discarded.

Decomposition:
- Shared package (game-of-life constants): ROWS, COLS, BOARD_W=ROWS*COLS, ROW_IDX_W, COUNT_W, the mode encoding (MANUAL=0, AUTO=1) and count-FSM state encodings (SNAP, COUNT, PUBLISH).
- One sub-module, row_popcount: combinational COLS-bit population count, instantiated once in the COUNT path. Button edge logic stays inline.

Test Plan:
- Reset then manual navigation: assert rst; release; BtnD pulse ×3 → row_index=3. Apply board_in row 3 = 16'hA5F0 → row_leds=16'hA5F0 one cycle after. BtnU pulse ×5 → row_index=0 (saturates).
- Bounds and simultaneity: BtnD pulse ×20 → row_index=15. BtnU and BtnD rising in the same cycle → row_index stays 15. BtnD held high for 100 cycles → a single increment only.
- Auto scroll: SCROLL_TICKS=4, BtnC pulse → auto_mode=1; row_index advances every 4 cycles, 15→0 wrap observed. BtnU pulses are ignored. BtnC again → auto_mode=0 and row_index frozen.
- Live count:
  - board_in all ones → count_valid pulses every 18 cycles with live_count=256.
  - board_in all zeros → live_count=0.
  - Checkerboard (16'hAAAA/16'h5555 rows) → live_count=128.
  - board_in changed mid-COUNT → the published value equals the SNAP-time board.
- Enable gating: deassert enable for 10 cycles mid-COUNT → no count_valid, row_index and row_leds hold. On reassert, the next count_valid arrives 10 cycles later than it would have without the stall.
- Async reset mid-scroll: rst asserted between clock edges in AUTO → outputs are at reset values before the next clk edge; auto_mode=0, live_count=0.
